// File: rtl/servo_pkg.sv
// servo_pkg: shared FSM state type, pulse-width defaults and per-axis aim/update helpers
package servo_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, HOLD = 2'd2, SEARCH = 2'd3} state_t;
  localparam int PW_MIN_DEF = 1000;
  localparam int PW_CTR_DEF = 1500;
  localparam int PW_MAX_DEF = 2000;
  function automatic logic signed [10:0] aim_err(input logic [9:0] aim, input int ctr);
    return 11'(aim) - 11'(ctr);
  endfunction
  function automatic logic in_db(input logic [9:0] aim, input int ctr, input int db);
    return int'(aim_err(aim, ctr)) <= db && int'(aim_err(aim, ctr)) >= -db;
  endfunction
  function automatic logic [10:0] axis_next(input logic [10:0] pos, input logic [9:0] aim,
                                            input int ctr, input int db, input int sh,
                                            input int lo, input int hi);
    int nxt;
    nxt = int'(pos) + int'(aim_err(aim, ctr) >>> sh);
    nxt = nxt < lo ? lo : nxt > hi ? hi : nxt;
    return in_db(aim, ctr, db) ? pos : 11'(nxt);
  endfunction
endpackage

// File: rtl/aim_servo_ctrl_if.sv
// aim_servo_ctrl_if: tracker inputs (v_sync, aim_x/y, aim_detected, enable) and servo outputs (pwm_pan/tilt, pan_us/tilt_us, state, on_target)
interface aim_servo_ctrl_if;
  import servo_pkg::*;
  logic v_sync;
  logic [9:0] aim_x;
  logic [9:0] aim_y;
  logic aim_detected;
  logic enable;
  logic pwm_pan;
  logic pwm_tilt;
  logic [10:0] pan_us;
  logic [10:0] tilt_us;
  state_t state;
  logic on_target;
  modport master (
    output v_sync, aim_x, aim_y, aim_detected, enable,
    input pwm_pan, pwm_tilt, pan_us, tilt_us, state, on_target
  );
  modport slave (
    input v_sync, aim_x, aim_y, aim_detected, enable,
    output pwm_pan, pwm_tilt, pan_us, tilt_us, state, on_target
  );
endinterface

// File: rtl/servo_pwm.sv
// servo_pwm: 1us prescaler + period counter; width_i captured at period start, pwm_o high for that many us
module servo_pwm #(
  parameter int CLK_PER_US = 25,
  parameter int PERIOD_US = 20000,
  parameter int PW_CTR = 1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] width_i,
  output logic        pwm_o
);
  localparam int PSW = $clog2(CLK_PER_US + 1);
  localparam int CW = $clog2(PERIOD_US + 1);
  logic [PSW-1:0] pre_q;
  logic [CW-1:0] cnt_q;
  logic [10:0] shadow_q;
  logic pwm_q, tick, wrap;
  assign tick = pre_q == PSW'(CLK_PER_US - 1);
  assign wrap = tick && cnt_q == CW'(PERIOD_US - 1);
  assign pwm_o = pwm_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      cnt_q <= '0;
      shadow_q <= 11'(PW_CTR);
      pwm_q <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      cnt_q <= wrap ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
      shadow_q <= wrap ? width_i : shadow_q;
      pwm_q <= 32'(cnt_q) < 32'(shadow_q);
    end
  end
endmodule

// File: rtl/aim_servo_ctrl.sv
// aim_servo_ctrl: frame-paced pan/tilt tracker FSM (IDLE/TRACK/HOLD/SEARCH) driving two servo PWMs; ports clk, reset, bus (aim_servo_ctrl_if.slave)
module aim_servo_ctrl import servo_pkg::*; #(
  parameter int CLK_PER_US = 25,
  parameter int PERIOD_US = 20000,
  parameter int PW_MIN = PW_MIN_DEF,
  parameter int PW_CTR = PW_CTR_DEF,
  parameter int PW_MAX = PW_MAX_DEF,
  parameter int CTR_X = 320,
  parameter int CTR_Y = 240,
  parameter int DEADBAND = 8,
  parameter int KP_SHIFT = 3,
  parameter int LOST_FRAMES = 30,
  parameter int SWEEP_STEP = 10
) (
  input logic clk,
  input logic reset,
  aim_servo_ctrl_if.slave bus
);
  localparam int LW = $clog2(LOST_FRAMES + 1);
  state_t state_q, state_d;
  logic [10:0] pan_q, pan_d, tilt_q, tilt_d, pan_upd, tilt_upd;
  logic [LW-1:0] lost_q, lost_d;
  logic dir_q, dir_d, on_q, on_d, vs_q, frame, centred, sw_hi, sw_lo;
  assign frame = vs_q & ~bus.v_sync;
  assign centred = in_db(bus.aim_x, CTR_X, DEADBAND) && in_db(bus.aim_y, CTR_Y, DEADBAND);
  assign pan_upd = axis_next(pan_q, bus.aim_x, CTR_X, DEADBAND, KP_SHIFT, PW_MIN, PW_MAX);
  assign tilt_upd = axis_next(tilt_q, bus.aim_y, CTR_Y, DEADBAND, KP_SHIFT, PW_MIN, PW_MAX);
  assign sw_hi = int'(pan_q) + SWEEP_STEP >= PW_MAX;
  assign sw_lo = int'(pan_q) - SWEEP_STEP <= PW_MIN;
  always_comb begin
    state_d = state_q;
    pan_d = pan_q;
    tilt_d = tilt_q;
    lost_d = lost_q;
    dir_d = dir_q;
    on_d = on_q;
    if (!bus.enable) begin
      state_d = IDLE;
      pan_d = 11'(PW_CTR);
      tilt_d = 11'(PW_CTR);
      lost_d = '0;
      on_d = 1'b0;
    end else if (frame) begin
      on_d = 1'b0;
      if (bus.aim_detected) begin
        state_d = TRACK;
        on_d = centred;
        lost_d = '0;
        pan_d = state_q == SEARCH ? pan_q : pan_upd;
        tilt_d = state_q == SEARCH ? tilt_q : tilt_upd;
      end else begin
        case (state_q)
          IDLE: state_d = TRACK;
          TRACK: begin
            state_d = HOLD;
            lost_d = LW'(1);
          end
          HOLD: begin
            lost_d = lost_q + 1'b1;
            if (lost_d == LW'(LOST_FRAMES)) begin
              state_d = SEARCH;
              tilt_d = 11'(PW_CTR);
            end
          end
          SEARCH: begin
            pan_d = dir_q ? (sw_lo ? 11'(PW_MIN) : pan_q - 11'(SWEEP_STEP))
                          : (sw_hi ? 11'(PW_MAX) : pan_q + 11'(SWEEP_STEP));
            dir_d = dir_q ? !sw_lo : sw_hi;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pan_q <= 11'(PW_CTR);
      tilt_q <= 11'(PW_CTR);
      lost_q <= '0;
      dir_q <= 1'b0;
      on_q <= 1'b0;
      vs_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pan_q <= pan_d;
      tilt_q <= tilt_d;
      lost_q <= lost_d;
      dir_q <= dir_d;
      on_q <= on_d;
      vs_q <= bus.v_sync;
    end
  end
  assign bus.state = state_q;
  assign bus.pan_us = pan_q;
  assign bus.tilt_us = tilt_q;
  assign bus.on_target = on_q;
  servo_pwm #(.CLK_PER_US(CLK_PER_US), .PERIOD_US(PERIOD_US), .PW_CTR(PW_CTR)) u_pan (
    .clk(clk), .reset(reset), .width_i(pan_q), .pwm_o(bus.pwm_pan)
  );
  servo_pwm #(.CLK_PER_US(CLK_PER_US), .PERIOD_US(PERIOD_US), .PW_CTR(PW_CTR)) u_tilt (
    .clk(clk), .reset(reset), .width_i(tilt_q), .pwm_o(bus.pwm_tilt)
  );
endmodule
